// File: rtl/stack_return_unit.sv
// Return sequencer: pops flags (RTI only), then PC low, then PC high from the stack
// and issues one-cycle restore pulses to fetch and the flag register.
module stack_return_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int PC_WIDTH    = 32,
  parameter int FLAG_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ret_start,
  input  logic                  rti_start,
  input  logic [15:0]           mem_data,
  output logic                  pop_req,
  output logic                  busy,
  output logic                  stall,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  pc_load,
  output logic [FLAG_WIDTH-1:0] flags_out,
  output logic                  flags_load
);

  typedef enum logic [2:0] {
    IDLE, POP_FLAGS, WAIT_FLAGS, POP_LO, WAIT_LO, POP_HI, WAIT_HI, DONE
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t                state_q;
  logic [1:0]            cnt_q;
  logic [15:0]           lo_q;
  logic [FLAG_WIDTH-1:0] flags_w_q;
  logic                  rti_q;
  logic                  pop_q, busy_q, pc_load_q, flags_load_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [FLAG_WIDTH-1:0] flags_q;

  // Outputs are registered: each is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lo_q         <= '0;
      flags_w_q    <= '0;
      rti_q        <= 1'b0;
      pop_q        <= 1'b0;
      busy_q       <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      pc_q         <= '0;
      flags_q      <= '0;
    end else begin
      pop_q        <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rti_start) begin
            state_q <= POP_FLAGS;
            rti_q   <= 1'b1;
            pop_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (ret_start) begin
            state_q <= POP_LO;
            rti_q   <= 1'b0;
            pop_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP_FLAGS: begin
          cnt_q   <= LAT_M1;
          state_q <= WAIT_FLAGS;
        end
        WAIT_FLAGS: begin
          if (cnt_q == 2'd0) begin
            flags_w_q <= mem_data[FLAG_WIDTH-1:0];
            state_q   <= POP_LO;
            pop_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        POP_LO: begin
          cnt_q   <= LAT_M1;
          state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (cnt_q == 2'd0) begin
            lo_q    <= mem_data;
            state_q <= POP_HI;
            pop_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        POP_HI: begin
          cnt_q   <= LAT_M1;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (cnt_q == 2'd0) begin
            pc_q      <= PC_WIDTH'({mem_data, lo_q});
            pc_load_q <= 1'b1;
            if (rti_q) begin
              flags_q      <= flags_w_q;
              flags_load_q <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop_req    = pop_q;
  assign busy       = busy_q;
  assign pc_out     = pc_q;
  assign pc_load    = pc_load_q;
  assign flags_out  = flags_q;
  assign flags_load = flags_load_q;
  assign stall      = busy_q | ((ret_start | rti_start) & (state_q == IDLE));

endmodule

// File: tb/tb_stack_return_unit.sv
// Bench: two units (latency 1 and 3) each reading from a behavioural stack memory.
module tb_stack_return_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ret_s[2], rti_s[2], pop_o[2], busy_o[2], stall_o[2], pcl_o[2], fll_o[2];
  logic [15:0] md[2];
  logic [31:0] pc_o[2];
  logic [2:0]  fl_o[2];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stack_return_unit #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .ret_start(ret_s[0]), .rti_start(rti_s[0]), .mem_data(md[0]),
    .pop_req(pop_o[0]), .busy(busy_o[0]), .stall(stall_o[0]), .pc_out(pc_o[0]),
    .pc_load(pcl_o[0]), .flags_out(fl_o[0]), .flags_load(fll_o[0]));

  stack_return_unit #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .ret_start(ret_s[1]), .rti_start(rti_s[1]), .mem_data(md[1]),
    .pop_req(pop_o[1]), .busy(busy_o[1]), .stall(stall_o[1]), .pc_out(pc_o[1]),
    .pc_load(pcl_o[1]), .flags_out(fl_o[1]), .flags_load(fll_o[1]));

  // Stack memories: a pop returns the top word after the configured latency;
  // cycles without a pop present random garbage so a mistimed capture shows up.
  logic [15:0] stk0[$];
  logic [15:0] stk1[$];
  logic [15:0] p1;
  logic [15:0] p3[3];

  always @(posedge clk) begin
    logic [15:0] v;
    v = 16'($urandom);
    if (pop_o[0] && stk0.size() > 0) v = stk0.pop_back();
    p1 <= v;
  end

  always @(posedge clk) begin
    logic [15:0] v;
    v = 16'($urandom);
    if (pop_o[1] && stk1.size() > 0) v = stk1.pop_back();
    p3[0] <= v;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign md[0] = p1;
  assign md[1] = p3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // op: 0 = RET, 1 = RTI, 2 = both starts together (RTI must win)
  task automatic run_op(input int op, input logic [15:0] hi, input logic [15:0] lo,
                        input logic [15:0] fw, input bit hold,
                        input logic [31:0] epc, input logic [2:0] efl);
    bit rti;
    int npop[2], nbusy[2], nstall[2], npcl[2], pclc[2], nfll[2];
    int pcyc[2][3];
    logic [31:0] pcv[2];
    logic [2:0]  flv[2];
    rti = (op != 0);
    for (int d = 0; d < 2; d++) begin
      npop[d] = 0; nbusy[d] = 0; nstall[d] = 0; npcl[d] = 0; pclc[d] = 0; nfll[d] = 0;
      pcv[d] = '0; flv[d] = '0;
      for (int i = 0; i < 3; i++) pcyc[d][i] = 0;
    end
    stk0.push_back(hi); stk0.push_back(lo);
    stk1.push_back(hi); stk1.push_back(lo);
    if (rti) begin stk0.push_back(fw); stk1.push_back(fw); end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ret_s[d] = (op != 1);
      rti_s[d] = (op != 0);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d start stall", d), 32'(stall_o[d]), 32'd1);
      chk($sformatf("u%0d start busy", d), 32'(busy_o[d]), 32'd0);
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (pop_o[d]) begin
          if (npop[d] < 3) pcyc[d][npop[d]] = c;
          npop[d]++;
        end
        if (busy_o[d]) nbusy[d]++;
        if (stall_o[d]) nstall[d]++;
        if (pcl_o[d]) begin npcl[d]++; pclc[d] = c; pcv[d] = pc_o[d]; end
        if (fll_o[d]) begin nfll[d]++; flv[d] = fl_o[d]; end
        if (hold ? !busy_o[d] : (c == 1)) begin
          ret_s[d] = 1'b0;
          rti_s[d] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      int ml, k, eb;
      ml = (d == 0) ? 1 : 3;
      k  = rti ? 3 : 2;
      eb = k * (ml + 1) + 1;
      chk($sformatf("u%0d pop count", d), npop[d], k);
      for (int i = 0; i < k; i++)
        chk($sformatf("u%0d pop%0d cycle", d, i), pcyc[d][i], 1 + i * (ml + 1));
      chk($sformatf("u%0d busy cycles", d), nbusy[d], eb);
      chk($sformatf("u%0d pc_load count", d), npcl[d], 1);
      chk($sformatf("u%0d pc_load cycle", d), pclc[d], eb);
      chk($sformatf("u%0d pc_out", d), pcv[d], epc);
      chk($sformatf("u%0d pc_out hold", d), pc_o[d], epc);
      chk($sformatf("u%0d flags_load count", d), nfll[d], rti ? 1 : 0);
      if (rti) begin
        chk($sformatf("u%0d flags_out", d), 32'(flv[d]), 32'(efl));
        chk($sformatf("u%0d flags_out hold", d), 32'(fl_o[d]), 32'(efl));
      end
      chk($sformatf("u%0d stack left", d), (d == 0) ? stk0.size() : stk1.size(), 0);
      if (!hold) chk($sformatf("u%0d stall cycles", d), nstall[d], eb);
    end
  endtask

  task automatic reset_mid();
    int npcl, npop;
    npcl = 0; npop = 0;
    stk0.push_back(16'h4321); stk0.push_back(16'h8765);
    stk1.push_back(16'h4321); stk1.push_back(16'h8765);
    @(negedge clk);
    ret_s[0] = 1'b1; ret_s[1] = 1'b1;
    @(negedge clk);
    ret_s[0] = 1'b0; ret_s[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d rst busy", d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("u%0d rst pop_req", d), 32'(pop_o[d]), 32'd0);
      chk($sformatf("u%0d rst pc_out", d), pc_o[d], 32'd0);
      chk($sformatf("u%0d rst flags_out", d), 32'(fl_o[d]), 32'd0);
      chk($sformatf("u%0d rst stall", d), 32'(stall_o[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    stk0.delete(); stk1.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (pcl_o[d] || fll_o[d]) npcl++;
        if (pop_o[d] || busy_o[d]) npop++;
      end
    end
    chk("post-reset pulses", npcl, 0);
    chk("post-reset activity", npop, 0);
  endtask

  typedef struct {
    int          op;
    logic [15:0] hi, lo, fw;
    bit          hold;
    logic [31:0] epc;
    logic [2:0]  efl;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 16'h0005, 16'h1234, 16'h0000, 1'b0, 32'h0005_1234, 3'b000};
    tbl[1] = '{1, 16'h0001, 16'hBEEF, 16'hFFF5, 1'b0, 32'h0001_BEEF, 3'b101};
    tbl[2] = '{2, 16'hA5A5, 16'h5A5A, 16'h0002, 1'b0, 32'hA5A5_5A5A, 3'b010};
    tbl[3] = '{0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 32'hFFFF_FFFF, 3'b000};
    tbl[4] = '{1, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000, 3'b111};
    tbl[5] = '{2, 16'h8000, 16'h0001, 16'h0004, 1'b1, 32'h8000_0001, 3'b100};

    for (int d = 0; d < 2; d++) begin ret_s[d] = 1'b0; rti_s[d] = 1'b0; end
    #1 reset = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d reset busy", d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("u%0d reset pop_req", d), 32'(pop_o[d]), 32'd0);
      chk($sformatf("u%0d reset pc_load", d), 32'(pcl_o[d]), 32'd0);
      chk($sformatf("u%0d reset flags_load", d), 32'(fll_o[d]), 32'd0);
      chk($sformatf("u%0d reset pc_out", d), pc_o[d], 32'd0);
      chk($sformatf("u%0d reset stall", d), 32'(stall_o[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].op, tbl[i].hi, tbl[i].lo, tbl[i].fw, tbl[i].hold, tbl[i].epc, tbl[i].efl);

    reset_mid();
    run_op(tbl[0].op, tbl[0].hi, tbl[0].lo, tbl[0].fw, 1'b0, tbl[0].epc, tbl[0].efl);

    for (int n = 0; n < 30; n++) begin
      int          op;
      logic [15:0] hi, lo, fw;
      bit          hold;
      op   = $urandom_range(0, 2);
      hi   = 16'($urandom);
      lo   = 16'($urandom);
      fw   = 16'($urandom);
      hold = 1'($urandom_range(0, 1));
      run_op(op, hi, lo, fw, hold, {hi, lo}, fw[2:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
